// File: rtl/merge_avlstrm.sv
// merge_avlstrm: packet-atomic round-robin 2:1 Avalon-ST merge with a 2-entry output skid buffer
// Input readies depend only on registered occupancy, never combinationally on out_ready.
module merge_avlstrm #(
   parameter int DATA_WIDTH  = 512,
   parameter int EMPTY_WIDTH = 6
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic [DATA_WIDTH-1:0]  in0_data,
   input  logic                   in0_valid,
   output logic                   in0_ready,
   input  logic                   in0_sop,
   input  logic                   in0_eop,
   input  logic [EMPTY_WIDTH-1:0] in0_empty,
   input  logic [DATA_WIDTH-1:0]  in1_data,
   input  logic                   in1_valid,
   output logic                   in1_ready,
   input  logic                   in1_sop,
   input  logic                   in1_eop,
   input  logic [EMPTY_WIDTH-1:0] in1_empty,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_sop,
   output logic                   out_eop,
   output logic [EMPTY_WIDTH-1:0] out_empty,
   output logic [31:0]            stats_in_pkt0,
   output logic [31:0]            stats_in_pkt1,
   output logic [31:0]            stats_out_pkt,
   output logic [31:0]            stats_err
);
   localparam int W = DATA_WIDTH + EMPTY_WIDTH + 2;
   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
   state_t         state_q, state_d;
   logic           last_q, last_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [W-1:0]   e0_q, e0_d, e1_q, e1_d, beat;
   logic [31:0]    pkt0_q, pkt0_d, pkt1_q, pkt1_d, opkt_q, opkt_d, err_q, err_d;
   logic           idle, nf, grant0, grant1, drop0, drop1, fwd0, fwd1, push, pop;
   always_comb begin
      idle      = state_q == IDLE;
      nf        = cnt_q != 2'd2;
      grant1    = idle && in1_valid && in1_sop && !(in0_valid && in0_sop && last_q);
      grant0    = idle && in0_valid && in0_sop && !grant1;
      drop0     = idle && in0_valid && !in0_sop;
      drop1     = idle && in1_valid && !in1_sop;
      in0_ready = !Rst && (drop0 || ((grant0 || state_q == LOCK0) && nf));
      in1_ready = !Rst && (drop1 || ((grant1 || state_q == LOCK1) && nf));
      fwd0      = in0_valid && in0_ready && !drop0;
      fwd1      = in1_valid && in1_ready && !drop1;
      push      = fwd0 || fwd1;
      pop       = cnt_q != 2'd0 && out_ready;
      beat      = fwd1 ? {in1_data, in1_sop, in1_eop, in1_empty} : {in0_data, in0_sop, in0_eop, in0_empty};
      out_valid = cnt_q != 2'd0;
      {out_data, out_sop, out_eop, out_empty} = e0_q;
      state_d   = fwd0 ? (in0_eop ? IDLE : LOCK0) : fwd1 ? (in1_eop ? IDLE : LOCK1) : state_q;
      last_d    = (idle && push) ? fwd1 : last_q;
      cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
      // Head advances on pop; the incoming beat lands in the first free slot after the pop.
      e0_d      = (pop && cnt_q == 2'd2) ? e1_q :
                  (push && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1))) ? beat : e0_q;
      e1_d      = (push && ((cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop))) ? beat : e1_q;
      pkt0_d    = pkt0_q + {31'b0, fwd0 && in0_eop};
      pkt1_d    = pkt1_q + {31'b0, fwd1 && in1_eop};
      opkt_d    = opkt_q + {31'b0, pop && out_eop};
      err_d     = err_q + {31'b0, drop0} + {31'b0, drop1};
   end
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= 2'd0;
         e0_q    <= '0;
         e1_q    <= '0;
         pkt0_q  <= '0;
         pkt1_q  <= '0;
         opkt_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         e0_q    <= e0_d;
         e1_q    <= e1_d;
         pkt0_q  <= pkt0_d;
         pkt1_q  <= pkt1_d;
         opkt_q  <= opkt_d;
         err_q   <= err_d;
      end
   end
   assign stats_in_pkt0 = pkt0_q;
   assign stats_in_pkt1 = pkt1_q;
   assign stats_out_pkt = opkt_q;
   assign stats_err     = err_q;
endmodule

// File: tb/tb_merge_avlstrm.sv
// tb_merge_avlstrm: directed self-checking bench for the packet-atomic 2:1 merge
module tb_merge_avlstrm;
   logic         Clk, Rst;
   logic [511:0] in0_data, in1_data, out_data;
   logic         in0_valid, in0_ready, in0_sop, in0_eop;
   logic         in1_valid, in1_ready, in1_sop, in1_eop;
   logic [5:0]   in0_empty, in1_empty, out_empty;
   logic         out_valid, out_ready, out_sop, out_eop;
   logic [31:0]  stats_in_pkt0, stats_in_pkt1, stats_out_pkt, stats_err;
   int checks = 0, failures = 0, cyc = 0;
   int eop0_cyc, sop1_cyc;
   logic saw_stall0;
   typedef struct {logic [511:0] d; logic s; logic e; logic [5:0] m; int c;} rec_t;
   rec_t oq[$];

   merge_avlstrm dut (
      .Clk(Clk), .Rst(Rst),
      .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
      .in0_sop(in0_sop), .in0_eop(in0_eop), .in0_empty(in0_empty),
      .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
      .in1_sop(in1_sop), .in1_eop(in1_eop), .in1_empty(in1_empty),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
      .stats_in_pkt0(stats_in_pkt0), .stats_in_pkt1(stats_in_pkt1),
      .stats_out_pkt(stats_out_pkt), .stats_err(stats_err)
   );

   initial Clk = 0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   always @(negedge Clk) begin
      if (!Rst) begin
         if (out_valid && out_ready) oq.push_back('{out_data, out_sop, out_eop, out_empty, cyc});
         if (in0_valid && in0_ready && in0_eop) eop0_cyc = cyc;
         if (in1_valid && in1_ready && in1_sop) sop1_cyc = cyc;
         if (in0_valid && !in0_ready) saw_stall0 = 1;
      end
   end

   task automatic drive(input int ch, input logic v, input int d, input logic s, input logic e, input logic [5:0] m);
      if (ch == 0) begin
         in0_valid = v; in0_data = 512'(d); in0_sop = s; in0_eop = e; in0_empty = m;
      end else begin
         in1_valid = v; in1_data = 512'(d); in1_sop = s; in1_eop = e; in1_empty = m;
      end
   endtask

   task automatic send(input int ch, input int n, input int base, input logic [5:0] emp);
      int t;
      for (int b = 0; b < n; b++) begin
         drive(ch, 1, base + b, b == 0, b == n - 1, (b == n - 1) ? emp : 6'd0);
         t = 0;
         @(negedge Clk);
         while (!(ch == 0 ? in0_ready : in1_ready) && t < 200) begin
            @(negedge Clk);
            t++;
         end
         checks++;
         if (t >= 200) begin
            failures++;
            $display("FAIL send_timeout ch=%0d beat=%0d ready=0 required=1", ch, b);
         end
         @(posedge Clk); #1;
      end
      drive(ch, 0, 0, 0, 0, 0);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Rst = 1;
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      out_ready = 1;
      idle_cycles(2);
      Rst = 0;
      oq.delete();
      saw_stall0 = 0;
   endtask

   task automatic test_reset();
      Rst = 1;
      drive(0, 1, 5, 1, 0, 0);
      drive(1, 1, 6, 1, 0, 0);
      out_ready = 1;
      idle_cycles(2);
      @(negedge Clk);
      checks++;
      if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready got=%b%b required=00", in0_ready, in1_ready);
      end
      @(posedge Clk); #1;
      Rst = 0;
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      oq.delete();
      @(negedge Clk);
      checks++;
      if (out_valid !== 0 || out_sop !== 0 || out_eop !== 0 || out_empty !== 0 || out_data !== 512'd0) begin
         failures++;
         $display("FAIL reset_out got v=%b s=%b e=%b m=%0d d=%0h required all 0", out_valid, out_sop, out_eop, out_empty, out_data[31:0]);
      end
      checks++;
      if ({stats_in_pkt0, stats_in_pkt1, stats_out_pkt, stats_err} !== 128'd0) begin
         failures++;
         $display("FAIL reset_stats got=%0d/%0d/%0d/%0d required=0/0/0/0", stats_in_pkt0, stats_in_pkt1, stats_out_pkt, stats_err);
      end
      @(posedge Clk); #1;
   endtask

   task automatic test_single();
      int ed[3] = '{100, 101, 102};
      do_reset();
      send(0, 3, 100, 6'd5);
      idle_cycles(4);
      checks++;
      if (oq.size() !== 3) begin
         failures++;
         $display("FAIL single_count got=%0d required=3", oq.size());
      end else for (int i = 0; i < 3; i++) begin
         checks++;
         if (oq[i].d !== 512'(ed[i]) || oq[i].s !== (i == 0) || oq[i].e !== (i == 2) ||
             (i == 2 && oq[i].m !== 6'd5) || oq[i].c !== oq[0].c + i) begin
            failures++;
            $display("FAIL single_beat%0d got d=%0d s=%b e=%b m=%0d c=%0d required d=%0d s=%b e=%b m=5 c=%0d",
                     i, oq[i].d[31:0], oq[i].s, oq[i].e, oq[i].m, oq[i].c, ed[i], i == 0, i == 2, oq[0].c + i);
         end
      end
      checks++;
      if (stats_in_pkt0 !== 1 || stats_out_pkt !== 1 || stats_in_pkt1 !== 0) begin
         failures++;
         $display("FAIL single_stats got in0=%0d in1=%0d out=%0d required 1/0/1", stats_in_pkt0, stats_in_pkt1, stats_out_pkt);
      end
   endtask

   task automatic test_tie();
      int ed[6] = '{200, 201, 300, 301, 400, 500};
      do_reset();
      fork
         send(0, 2, 200, 6'd1);
         send(1, 2, 300, 6'd2);
      join
      fork
         send(0, 1, 400, 6'd0);
         send(1, 1, 500, 6'd0);
      join
      idle_cycles(4);
      checks++;
      if (oq.size() !== 6) begin
         failures++;
         $display("FAIL tie_count got=%0d required=6", oq.size());
      end else for (int i = 0; i < 6; i++) begin
         checks++;
         if (oq[i].d !== 512'(ed[i]) || (i < 4 && oq[i].c !== oq[0].c + i)) begin
            failures++;
            $display("FAIL tie_beat%0d got d=%0d c=%0d required d=%0d c=%0d", i, oq[i].d[31:0], oq[i].c, ed[i], oq[0].c + i);
         end
      end
      checks++;
      if (stats_in_pkt0 !== 2 || stats_in_pkt1 !== 2 || stats_out_pkt !== 4) begin
         failures++;
         $display("FAIL tie_stats got in0=%0d in1=%0d out=%0d required 2/2/4", stats_in_pkt0, stats_in_pkt1, stats_out_pkt);
      end
   endtask

   task automatic test_lock();
      int ed[6] = '{600, 601, 602, 603, 700, 701};
      do_reset();
      fork
         send(0, 4, 600, 6'd3);
         begin
            idle_cycles(2);
            send(1, 2, 700, 6'd0);
         end
      join
      idle_cycles(4);
      checks++;
      if (oq.size() !== 6) begin
         failures++;
         $display("FAIL lock_count got=%0d required=6", oq.size());
      end else for (int i = 0; i < 6; i++) begin
         checks++;
         if (oq[i].d !== 512'(ed[i]) || oq[i].c !== oq[0].c + i) begin
            failures++;
            $display("FAIL lock_beat%0d got d=%0d c=%0d required d=%0d c=%0d", i, oq[i].d[31:0], oq[i].c, ed[i], oq[0].c + i);
         end
      end
      checks++;
      if (sop1_cyc !== eop0_cyc + 1) begin
         failures++;
         $display("FAIL lock_switch got sop1_cyc=%0d required=%0d", sop1_cyc, eop0_cyc + 1);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      fork
         send(0, 5, 800, 6'd4);
         begin
            out_ready = 1;
            idle_cycles(1);
            out_ready = 0;
            idle_cycles(2);
            out_ready = 1;
         end
      join
      idle_cycles(5);
      checks++;
      if (oq.size() !== 5) begin
         failures++;
         $display("FAIL bp_count got=%0d required=5", oq.size());
      end else for (int i = 0; i < 5; i++) begin
         checks++;
         if (oq[i].d !== 512'(800 + i) || oq[i].s !== (i == 0) || oq[i].e !== (i == 4)) begin
            failures++;
            $display("FAIL bp_beat%0d got d=%0d s=%b e=%b required d=%0d s=%b e=%b", i, oq[i].d[31:0], oq[i].s, oq[i].e, 800 + i, i == 0, i == 4);
         end
      end
      checks++;
      if (saw_stall0 !== 1'b1) begin
         failures++;
         $display("FAIL bp_stall got in0_ready_low=%b required=1", saw_stall0);
      end
      checks++;
      if (stats_out_pkt !== 1) begin
         failures++;
         $display("FAIL bp_stats got out=%0d required=1", stats_out_pkt);
      end
   endtask

   task automatic test_err();
      do_reset();
      drive(1, 1, 77, 0, 1, 6'd2);
      @(negedge Clk);
      checks++;
      if (in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
         failures++;
         $display("FAIL err_ready got in1=%b in0=%b required in1=1 in0=0", in1_ready, in0_ready);
      end
      @(posedge Clk); #1;
      drive(1, 0, 0, 0, 0, 0);
      idle_cycles(3);
      checks++;
      if (stats_err !== 1 || oq.size() !== 0 || stats_in_pkt1 !== 0) begin
         failures++;
         $display("FAIL err_drop got err=%0d outbeats=%0d in1pkt=%0d required 1/0/0", stats_err, oq.size(), stats_in_pkt1);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(0, 1, 1000, 1, 0, 0);
      idle_cycles(1);
      drive(0, 1, 1001, 0, 0, 0);
      idle_cycles(1);
      drive(0, 1, 1002, 0, 0, 0);
      Rst = 1;
      @(negedge Clk);
      checks++;
      if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_ready got=%b%b required=00", in0_ready, in1_ready);
      end
      @(posedge Clk); #1;
      Rst = 0;
      drive(0, 0, 0, 0, 0, 0);
      oq.delete();
      @(negedge Clk);
      checks++;
      if (out_valid !== 1'b0 || {stats_in_pkt0, stats_in_pkt1, stats_out_pkt, stats_err} !== 128'd0) begin
         failures++;
         $display("FAIL rstmid_state got v=%b stats=%0d/%0d/%0d/%0d required v=0 stats 0", out_valid, stats_in_pkt0, stats_in_pkt1, stats_out_pkt, stats_err);
      end
      @(posedge Clk); #1;
      send(1, 1, 900, 6'd7);
      idle_cycles(3);
      checks++;
      if (oq.size() !== 1) begin
         failures++;
         $display("FAIL rstmid_count got=%0d required=1", oq.size());
      end else begin
         checks++;
         if (oq[0].d !== 512'd900 || oq[0].s !== 1'b1 || oq[0].e !== 1'b1 || oq[0].m !== 6'd7) begin
            failures++;
            $display("FAIL rstmid_beat got d=%0d s=%b e=%b m=%0d required d=900 s=1 e=1 m=7", oq[0].d[31:0], oq[0].s, oq[0].e, oq[0].m);
         end
      end
      checks++;
      if (stats_in_pkt1 !== 1 || stats_in_pkt0 !== 0) begin
         failures++;
         $display("FAIL rstmid_stats got in0=%0d in1=%0d required 0/1", stats_in_pkt0, stats_in_pkt1);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_lock();
      test_backpressure();
      test_err();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/merge_avlstrm.md
Name: merge_avlstrm

Overview:
- 2:1 packet-atomic merge of two Avalon-ST packet streams into one stream. It is the inverse of the service-level fork.
- Rejoins the nocheck and check packet paths, or any two split packet channels, before the downstream channel FIFO.
- Beats of one packet are never interleaved with beats of the other input.
- Arbitration between inputs is round-robin at packet boundaries.

Parameters:
- DATA_WIDTH, 512, width of the packet data bus.
- EMPTY_WIDTH, 6, width of the empty field (log2 of DATA_WIDTH/8).

Ports:
- Clk  in  1  clock
- Rst  in  1  synchronous active-high reset
- in0_data  in  DATA_WIDTH  input 0 beat data
- in0_valid  in  1  input 0 beat valid
- in0_ready  out  1  input 0 ready (ready latency 0)
- in0_sop  in  1  input 0 start of packet
- in0_eop  in  1  input 0 end of packet
- in0_empty  in  EMPTY_WIDTH  input 0 empty bytes, meaningful on eop only
- in1_data, in1_valid, in1_ready, in1_sop, in1_eop, in1_empty: same as in0_* for input 1
- out_data  out  DATA_WIDTH  merged beat data
- out_valid  out  1  merged beat valid
- out_ready  in  1  downstream ready
- out_sop  out  1  merged start of packet
- out_eop  out  1  merged end of packet
- out_empty  out  EMPTY_WIDTH  merged empty
- stats_in_pkt0  out  32  packets (eop beats) accepted from in0
- stats_in_pkt1  out  32  packets accepted from in1
- stats_out_pkt  out  32  packets (eop beats) delivered on out
- stats_err  out  32  non-sop beats dropped while no packet is in progress

Behaviour:
- Handshake: a beat transfers when valid and ready are both high in the same cycle.
- Output stage is a 2-entry skid buffer. in*_ready never depends combinationally on out_ready.
- Latency: an accepted input beat appears on out_valid in the next cycle at the earliest.
- Full throughput: one beat per cycle when out_ready is held high.
- FSM has three states: IDLE, LOCK0, LOCK1.
- IDLE, grant decision:
  - Candidates are the inputs with valid&sop.
  - If both inputs are candidates, grant the input not granted last. last_grant resets to 1, so in0 wins the first tie.
  - The granted input's ready equals skid-not-full. The other input's ready is 0.
  - On the accepted sop beat: if eop is also set (single-beat packet), stay in IDLE. Otherwise go to LOCKx.
  - last_grant updates when the sop beat is accepted.
- IDLE, protocol error:
  - An input with valid&!sop and no grant is given ready=1.
  - Its beat is consumed and dropped, and stats_err increments.
  - If an error beat and a valid sop arrive in the same cycle, both are handled: the sop is granted, the error beat is dropped.
- LOCKx:
  - Only inx_ready may be asserted, equal to skid-not-full.
  - The other input is stalled regardless of its valid.
  - Go to IDLE on the accepted beat with eop.
  - A sop beat seen mid-packet is forwarded unchanged. No check is made.
- No-bubble switch: the grant decision is combinational in IDLE. A new packet's sop is accepted in the cycle right after the previous eop is accepted, from either input.
- Skid buffer:
  - Full means 2 entries held. Input readies are then 0.
  - out_valid = skid non-empty. Output fields come from the head entry.
  - Simultaneous push and pop keeps the occupancy unchanged.
- Counters: 32-bit, wrap modulo 2^32, incremented on the accepting handshake.
- Reset, including mid-packet:
  - FSM goes to IDLE, last_grant to 1, skid buffer to empty.
  - out_valid=0, out_sop=0, out_eop=0, out_empty=0, out_data=0.
  - in0_ready=0 and in1_ready=0 during the reset cycle.
  - All stats are 0.
  - A partially forwarded packet is abandoned. The downstream sees a truncated packet without eop, which is accepted behaviour.

Test Plan:
- Single 3-beat packet on in0 (sop on beat 1, eop on beat 3, empty=5), out_ready=1 -> out beats in cycles 1-3 with sop/eop/empty=5 in the same positions; stats_in_pkt0=1, stats_out_pkt=1.
- Both inputs present sop in the same cycle, 2-beat packets, after reset -> in0 packet first, then in1 packet with no idle cycle between; next tie goes to in0 again; data never interleaved.
- in1 sop arrives while in0 is on beat 2 of a 4-beat packet -> in1_ready=0 until in0's eop is accepted; in1 sop follows on the next cycle.
- out_ready toggles 1,0,0,1 during a 5-beat packet -> no beat lost or duplicated; in0_ready drops within 1 cycle once 2 entries are buffered.
- Non-sop valid beat on in1 while in IDLE -> beat dropped, stats_err=1, nothing on out.
- Rst asserted on beat 2 of a 4-beat packet -> next cycle out_valid=0, all stats 0; a new sop on in1 is accepted afterwards.
